latch_history_bank: RTL and testbench

- Parametrised successor to the single-byte transparent-latch/LED demo block.
- Captures a WIDTH-bit input word on each debounced-free rising edge of a capture strobe into a DEPTH-entry ring buffer of edge-triggered registers.
- Drives LEDs with either the live input or any stored entry, selected by index relative to the newest capture.
- Adds capture-activity indication with a pulse stretcher; sits between board switches/buttons and LEDs.

---
 rtl/latch_history_bank.sv | 116 +++++++++++
 tb/tb_latch_history_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/latch_history_bank.sv
// Purpose: captures D on each synchronised rising edge of cap into a DEPTH-deep ring and drives LEDs from live D or a stored entry.
// Latency: the write lands 2 cycles after cap is first sampled high; led is registered 1 cycle after sel/rd_idx/D.
// Backpressure: none. Captures never stall, and a full bank overwrites its oldest entry.
module latch_history_bank #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int STRETCH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           D,
    input  logic                       cap,
    input  logic                       clr,
    input  logic                       sel,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           led,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       cap_alert,
    output logic                       sel_alert
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STRETCH + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [SW-1:0] STRETCH_C = SW'(STRETCH);

    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [SW-1:0]    alert_q, alert_d;
    logic             sel_alert_q, sel_alert_d;
    logic             cap_pulse;
    logic [AW-1:0]    rd_addr;

    always_comb begin
        s1_d      = cap;
        s2_d      = s1_q;
        s3_d      = s2_q;
        cap_pulse = s2_q & ~s3_q;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // Clear beats a coincident capture, so the pulse is simply dropped.
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (cap_pulse) begin
            mem_d[wr_ptr_q] = D;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (count_q != DEPTH_C) begin
                count_d = count_q + CW'(1);
            end
        end

        // Reads see the pre-capture pointer, so a new entry shows up a cycle later.
        rd_addr = wr_ptr_q - AW'(1) - rd_idx;
        if (!sel) begin
            led_d = D;
        end else if ({1'b0, rd_idx} < count_q) begin
            led_d = mem_q[rd_addr];
        end else begin
            led_d = '0;
        end

        if (cap_pulse) begin
            alert_d = STRETCH_C;
        end else if (alert_q != '0) begin
            alert_d = alert_q - SW'(1);
        end else begin
            alert_d = '0;
        end

        sel_alert_d = sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser presets high so a strobe held through reset cannot capture.
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s3_q        <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            count_q     <= '0;
            led_q       <= '0;
            alert_q     <= '0;
            sel_alert_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            led_q       <= led_d;
            alert_q     <= alert_d;
            sel_alert_q <= sel_alert_d;
        end
    end

    assign led       = led_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign cap_alert = (alert_q != '0);
    assign sel_alert = sel_alert_q;
endmodule

// File: tb/tb_latch_history_bank.sv
// Bench for latch_history_bank: directed vector table plus random traffic, both checked against a queue-based history model.
module tb_latch_history_bank;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int STRETCH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] D;
    logic             cap;
    logic             clr;
    logic             sel;
    logic [1:0]       rd_idx;
    logic [WIDTH-1:0] led;
    logic [2:0]       count;
    logic             full;
    logic             cap_alert;
    logic             sel_alert;

    latch_history_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STRETCH(STRETCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .D         (D),
        .cap       (cap),
        .clr       (clr),
        .sel       (sel),
        .rd_idx    (rd_idx),
        .led       (led),
        .count     (count),
        .full      (full),
        .cap_alert (cap_alert),
        .sel_alert (sel_alert)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One record per clock: inputs applied before the edge, expectations
    // (-1 = don't care) checked just after it.
    typedef struct {
        string nm;
        bit    r;
        bit    c;
        bit    cl;
        bit    s;
        int    idx;
        int    d;
        int    e_led;
        int    e_cnt;
        int    e_alert;
        int    e_sel;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: newest capture at the front of the queue.
    logic [WIDTH-1:0] hist[$];
    bit               cap_log[$];
    int               alert_m = 0;
    logic [WIDTH-1:0] led_m   = '0;
    bit               sel_m   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input bit r, input bit c, input bit cl, input bit s,
                                input int idx, input int d, input int el, input int ec,
                                input int ea, input int es);
        vec_t v;
        v.nm = nm; v.r = r; v.c = c; v.cl = cl; v.s = s; v.idx = idx; v.d = d;
        v.e_led = el; v.e_cnt = ec; v.e_alert = ea; v.e_sel = es;
        tbl.push_back(v);
    endfunction

    // Cap high for three clocks (write on the third), then low for one.
    function automatic void cap4(input string nm, input int d, input int cnt_pre, input int cnt_post);
        add(nm, 0, 1, 0, 1, 0, d, -1, cnt_pre,  -1, 1);
        add(nm, 0, 1, 0, 1, 0, d, -1, cnt_pre,  -1, 1);
        add(nm, 0, 1, 0, 1, 0, d, -1, cnt_post,  1, 1);
        add(nm, 0, 0, 0, 1, 0, d,  d, cnt_post,  1, 1);
    endfunction

    task automatic model_edge(input vec_t v);
        bit pulse;
        if (v.r) begin
            hist.delete();
            cap_log = '{1'b1, 1'b1, 1'b1};
            alert_m = 0;
            led_m   = '0;
            sel_m   = 1'b0;
        end else begin
            // A capture needs cap high two samples back and low three samples back.
            pulse = cap_log[1] && !cap_log[2];
            if (!v.s)                    led_m = v.d[WIDTH-1:0];
            else if (v.idx < hist.size()) led_m = hist[v.idx];
            else                          led_m = '0;
            if (v.cl) begin
                hist.delete();
            end else if (pulse) begin
                hist.push_front(v.d[WIDTH-1:0]);
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end
            if (pulse)             alert_m = STRETCH;
            else if (alert_m > 0)  alert_m = alert_m - 1;
            sel_m = v.s;
            cap_log.push_front(v.c);
            void'(cap_log.pop_back());
        end
    endtask

    task automatic step(input vec_t v);
        rst    = v.r;
        cap    = v.c;
        clr    = v.cl;
        sel    = v.s;
        rd_idx = v.idx[1:0];
        D      = v.d[WIDTH-1:0];
        @(posedge clk);
        model_edge(v);
        #1;
        chk({v.nm, "/model_led"},   32'(led),       32'(led_m));
        chk({v.nm, "/model_count"}, 32'(count),     32'(hist.size()));
        chk({v.nm, "/model_full"},  32'(full),      32'(hist.size() == DEPTH));
        chk({v.nm, "/model_alert"}, 32'(cap_alert), 32'(alert_m != 0));
        chk({v.nm, "/model_sel"},   32'(sel_alert), 32'(sel_m));
        if (v.e_led >= 0)   chk({v.nm, "/led"},       32'(led),       32'(v.e_led));
        if (v.e_cnt >= 0) begin
            chk({v.nm, "/count"}, 32'(count), 32'(v.e_cnt));
            chk({v.nm, "/full"},  32'(full),  32'(v.e_cnt == DEPTH));
        end
        if (v.e_alert >= 0) chk({v.nm, "/cap_alert"}, 32'(cap_alert), 32'(v.e_alert));
        if (v.e_sel >= 0)   chk({v.nm, "/sel_alert"}, 32'(sel_alert), 32'(v.e_sel));
    endtask

    initial begin
        vec_t rv;
        bit   cap_r;
        cap_log = '{1'b1, 1'b1, 1'b1};
        rst = 1'b1; cap = 1'b1; clr = 1'b0; sel = 1'b0; rd_idx = '0; D = '0;

        // Strobe held high through and after reset must not capture.
        add("rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add("cap_held", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("cap_low", 0, 0, 0, 1, 0, 8'h11, 0, 0, 0, 1);
        add("cap_low", 0, 0, 0, 1, 0, 8'h11, 0, 0, 0, 1);
        cap4("cap11", 8'h11, 0, 1);
        cap4("cap22", 8'h22, 1, 2);
        cap4("cap33", 8'h33, 2, 3);
        add("rd0", 0, 0, 0, 1, 0, 0, 8'h33, 3, -1, 1);
        add("rd1", 0, 0, 0, 1, 1, 0, 8'h22, 3, -1, 1);
        add("rd2", 0, 0, 0, 1, 2, 0, 8'h11, 3, -1, 1);
        add("rd3", 0, 0, 0, 1, 3, 0, 8'h00, 3, -1, 1);
        // Reset lands on the edge where a pending capture would have written.
        add("pre_rst", 0, 1, 0, 1, 0, 0, 8'h33, 3, -1, 1);
        add("pre_rst", 0, 1, 0, 1, 0, 0, 8'h33, 3, -1, 1);
        add("mid_rst", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add("idle",    0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 6; i++) cap4("wrap", i, (i - 1 > 4) ? 4 : i - 1, (i > 4) ? 4 : i);
        add("wrd0", 0, 0, 0, 1, 0, 0, 8'h06, 4, -1, 1);
        add("wrd1", 0, 0, 0, 1, 1, 0, 8'h05, 4, -1, 1);
        add("wrd2", 0, 0, 0, 1, 2, 0, 8'h04, 4, -1, 1);
        add("wrd3", 0, 0, 0, 1, 3, 0, 8'h03, 4, -1, 1);
        // Clear coincident with the capture pulse drops the capture.
        add("clr_grp", 0, 1, 0, 1, 0, 8'hAA, -1, 4, -1, 1);
        add("clr_grp", 0, 1, 0, 1, 0, 8'hAA, -1, 4, -1, 1);
        add("clr_hit", 0, 1, 1, 1, 0, 8'hAA, 8'h06, 0, 1, 1);
        add("clr_low", 0, 0, 0, 1, 0, 8'hAA, 0, 0, -1, 1);
        for (int i = 0; i < 4; i++) add("clr_rd", 0, 0, 0, 1, i, 8'hAA, 0, 0, -1, 1);
        cap4("cap_bb", 8'hBB, 0, 1);
        add("rd_bb", 0, 0, 0, 1, 0, 0, 8'hBB, 1, -1, 1);
        add("live5a", 0, 0, 0, 0, 0, 8'h5A, 8'h5A, 1, -1, 0);
        add("liveA5", 0, 0, 0, 0, 0, 8'hA5, 8'hA5, 1, 0, 0);
        add("sel_on", 0, 0, 0, 1, 0, 8'h00, 8'hBB, 1, 0, 1);
        // Two pulses two cycles apart: alert retriggers and stays high.
        add("al0",  0, 0, 0, 1, 0, 8'hC1, -1, 1, 0, 1);
        add("al1",  0, 1, 0, 1, 0, 8'hC1, -1, 1, 0, 1);
        add("al2",  0, 0, 0, 1, 0, 8'hC1, -1, 1, 0, 1);
        add("al3",  0, 1, 0, 1, 0, 8'hC1, -1, 2, 1, 1);
        add("al4",  0, 0, 0, 1, 0, 8'hC1, -1, 2, 1, 1);
        add("al5",  0, 0, 0, 1, 0, 8'hC2, 8'hC1, 3, 1, 1);
        add("al6",  0, 0, 0, 1, 0, 8'hC2, 8'hC2, 3, 1, 1);
        add("al7",  0, 0, 0, 1, 0, 8'hC2, -1, 3, 1, 1);
        add("al8",  0, 0, 0, 1, 0, 8'hC2, -1, 3, 1, 1);
        add("al9",  0, 0, 0, 1, 0, 8'hC2, -1, 3, 0, 1);
        add("al10", 0, 0, 0, 1, 0, 8'hC2, -1, 3, 0, 1);

        foreach (tbl[i]) step(tbl[i]);

        cap_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) cap_r = ~cap_r;
            rv.nm      = "rand";
            rv.r       = ($urandom_range(0, 63) == 0);
            rv.c       = cap_r;
            rv.cl      = ($urandom_range(0, 15) == 0);
            rv.s       = ($urandom_range(0, 3) != 0);
            rv.idx     = int'($urandom_range(0, DEPTH - 1));
            rv.d       = int'($urandom_range(0, 255));
            rv.e_led   = -1;
            rv.e_cnt   = -1;
            rv.e_alert = -1;
            rv.e_sel   = -1;
            step(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
